// File: rtl/mem_arbiter.sv
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one single-port synchronous memory between a read-only
//               fetch requester (I) and a load/store requester (D) using a
//               req/ack handshake. Optional macro MEM_ARB_ROUND_ROBIN_EN
//               selects round-robin arbitration instead of fixed D-over-I.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_ack,
  output logic [31:0]           if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [3:0]            d_be,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [31:0]           d_wdata,
  output logic                  d_ack,
  output logic [31:0]           d_rdata,
  output logic                  mem_en,
  output logic [3:0]            mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  output logic                  busy,
  output logic                  gnt_d
);

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_wait = 2'd1;
  localparam logic [1:0] c_resp = 2'd2;
  localparam logic [2:0] c_lat  = 3'(MEM_LATENCY);

  logic [1:0] r_state;
  logic [2:0] r_cnt;
  logic       r_we;
  logic       w_any;
  logic       w_pick_d;
  logic       w_wr;

  assign w_any = if_req | d_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Under contention the requester that did not own the last grant wins.
  assign w_pick_d = d_req & (~if_req | ~gnt_d);
`else
  assign w_pick_d = d_req;
`endif

  assign w_wr = w_pick_d & d_we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= c_idle;
      r_cnt     <= 3'd0;
      r_we      <= 1'b0;
      if_ack    <= 1'b0;
      if_rdata  <= 32'd0;
      d_ack     <= 1'b0;
      d_rdata   <= 32'd0;
      mem_en    <= 1'b0;
      mem_we    <= 4'd0;
      mem_addr  <= '0;
      mem_wdata <= 32'd0;
      busy      <= 1'b0;
      gnt_d     <= 1'b0;
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      mem_en <= 1'b0;
      mem_we <= 4'd0;
      case (r_state)
        c_idle, c_resp: begin
          if (w_any) begin
            r_state   <= c_wait;
            busy      <= 1'b1;
            gnt_d     <= w_pick_d;
            r_we      <= w_wr;
            r_cnt     <= c_lat;
            mem_en    <= 1'b1;
            mem_addr  <= w_pick_d ? d_addr : if_addr;
            mem_we    <= w_wr ? d_be : 4'd0;
            mem_wdata <= w_wr ? d_wdata : 32'd0;
          end else begin
            r_state <= c_idle;
          end
        end
        c_wait: begin
          // Reads leave WAIT on the edge where mem_rdata becomes valid.
          if (r_we || r_cnt == 3'd0) begin
            r_state <= c_resp;
            busy    <= 1'b0;
            if (gnt_d) begin
              d_ack <= 1'b1;
              if (!r_we) d_rdata <= mem_rdata;
            end else begin
              if_ack   <= 1'b1;
              if_rdata <= mem_rdata;
            end
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        default: begin
          r_state <= c_idle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Scoreboard bench for mem_arbiter; three instances with memory
//               latencies 1, 2 and 3 share the requester stimulus.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

  typedef struct {
    logic        is_d;
    logic [31:0] data;
    logic        chk;
    int          lat;
  } exp_t;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit c_rr = 1'b1;
  localparam int c_ncont = 4;
`else
  localparam bit c_rr = 1'b0;
  localparam int c_ncont = 2;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'd0;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [3:0]  d_be = 4'd0;
  logic [31:0] d_addr = 32'd0;
  logic [31:0] d_wdata = 32'd0;

  logic        if_ack_a    [3];
  logic [31:0] if_rdata_a  [3];
  logic        d_ack_a     [3];
  logic [31:0] d_rdata_a   [3];
  logic        mem_en_a    [3];
  logic [3:0]  mem_we_a    [3];
  logic [31:0] mem_addr_a  [3];
  logic [31:0] mem_wdata_a [3];
  logic [31:0] mem_rdata_a [3];
  logic        busy_a      [3];
  logic        gnt_d_a     [3];

  int   vectors = 0;
  int   errors  = 0;
  int   sel     = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int idx);
    logic [15:0] lo;
    lo = idx[15:0];
    return (idx == 64) ? 32'h00500093 : {8'hA5, lo, 8'h5A};
  endfunction

  genvar g;
  for (g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = g + 1;
    logic [31:0] mem  [256];
    logic [31:0] pipe [4];

    initial for (int i = 0; i < 256; i++) mem[i] = init_word(i);

    // Behavioural BRAM: data is valid LAT cycles after the mem_en cycle.
    always @(posedge clk) begin
      if (mem_en_a[g]) begin
        pipe[0] <= mem[mem_addr_a[g][9:2]];
        for (int b = 0; b < 4; b++)
          if (mem_we_a[g][b]) mem[mem_addr_a[g][9:2]][8*b +: 8] <= mem_wdata_a[g][8*b +: 8];
      end else begin
        pipe[0] <= 32'hBAD0BAD0;
      end
      for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
    end
    assign mem_rdata_a[g] = pipe[LAT-1];

    mem_arbiter #(.ADDR_WIDTH(32), .MEM_LATENCY(LAT)) u_dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack_a[g]), .if_rdata(if_rdata_a[g]),
      .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack_a[g]), .d_rdata(d_rdata_a[g]),
      .mem_en(mem_en_a[g]), .mem_we(mem_we_a[g]), .mem_addr(mem_addr_a[g]),
      .mem_wdata(mem_wdata_a[g]), .mem_rdata(mem_rdata_a[g]),
      .busy(busy_a[g]), .gnt_d(gnt_d_a[g])
    );
  end

  task automatic do_reset();
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_be = 4'd0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if ({if_ack_a[i], d_ack_a[i], mem_en_a[i], busy_a[i], gnt_d_a[i]} !== 5'd0) begin
        errors++;
        $display("FAIL reset_ctrl dut%0d got %b want 00000", i,
                 {if_ack_a[i], d_ack_a[i], mem_en_a[i], busy_a[i], gnt_d_a[i]});
      end
      vectors++;
      if ((mem_we_a[i] | mem_addr_a[i] | mem_wdata_a[i] | if_rdata_a[i] | d_rdata_a[i]) !== 32'd0) begin
        errors++;
        $display("FAIL reset_data dut%0d we=%h addr=%h wd=%h ird=%h drd=%h want all 0", i,
                 mem_we_a[i], mem_addr_a[i], mem_wdata_a[i], if_rdata_a[i], d_rdata_a[i]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_fetch();
    exp_t e;
    int   en_cnt = 0;
    sel = 0; do_reset();
    if_addr = 32'h100; if_req = 1'b1;
    sb.push_back('{1'b0, 32'h00500093, 1'b1, 3});
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (mem_en_a[sel]) begin
        en_cnt++; vectors++;
        if (mem_addr_a[sel] !== 32'h100 || mem_we_a[sel] !== 4'd0) begin
          errors++;
          $display("FAIL fetch_en addr=%h we=%b want 00000100/0000", mem_addr_a[sel], mem_we_a[sel]);
        end
      end
      vectors++;
      if (d_ack_a[sel] !== 1'b0) begin
        errors++; $display("FAIL fetch_dack got %b want 0", d_ack_a[sel]);
      end
      if (if_ack_a[sel]) begin
        if_req = 1'b0;
        vectors++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL fetch_extra_ack got ack want none");
        end else begin
          e = sb.pop_front();
          vectors++;
          if (if_rdata_a[sel] !== e.data) begin
            errors++; $display("FAIL fetch_data got %h want %h", if_rdata_a[sel], e.data);
          end
          if (c !== e.lat) begin
            errors++; $display("FAIL fetch_lat got %0d want %0d", c, e.lat);
          end
        end
      end
    end
    vectors++;
    if (sb.size() != 0 || en_cnt != 1) begin
      errors++; $display("FAIL fetch_count pending=%0d en=%0d want 0/1", sb.size(), en_cnt);
    end
  endtask

  task automatic test_store_load();
    exp_t e;
    bit   done;
    sel = 1; do_reset();
    for (int t = 0; t < 2; t++) begin
      done = 1'b0;
      d_we = (t == 0); d_be = (t == 0) ? 4'b0011 : 4'b0000;
      d_addr = 32'h200; d_wdata = (t == 0) ? 32'hDEADBEEF : 32'd0; d_req = 1'b1;
      if (t == 0) sb.push_back('{1'b1, 32'd0, 1'b0, 2});
      else        sb.push_back('{1'b1, 32'hA500BEEF, 1'b1, 4});
      for (int c = 1; c <= 10 && !done; c++) begin
        @(negedge clk);
        if (mem_en_a[sel]) begin
          vectors++;
          if (mem_addr_a[sel] !== 32'h200 || mem_we_a[sel] !== d_be || mem_wdata_a[sel] !== d_wdata) begin
            errors++;
            $display("FAIL sl_en%0d addr=%h we=%b wd=%h want 00000200/%b/%h", t,
                     mem_addr_a[sel], mem_we_a[sel], mem_wdata_a[sel], d_be, d_wdata);
          end
        end
        vectors++;
        if (if_ack_a[sel] !== 1'b0) begin
          errors++; $display("FAIL sl_iack got %b want 0", if_ack_a[sel]);
        end
        if (d_ack_a[sel]) begin
          d_req = 1'b0; done = 1'b1;
          e = sb.pop_front();
          vectors++;
          if (c !== e.lat) begin
            errors++; $display("FAIL sl_lat%0d got %0d want %0d", t, c, e.lat);
          end
          if (e.chk && d_rdata_a[sel] !== e.data) begin
            errors++; $display("FAIL sl_data got %h want %h", d_rdata_a[sel], e.data);
          end
        end
      end
      vectors++;
      if (!done) begin
        errors++; $display("FAIL sl_timeout%0d got no d_ack want d_ack", t);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_contention();
    exp_t e;
    int   cnt = 0, n_done = 0;
    logic got_d;
    sel = 0; do_reset();
    if_addr = 32'h4; d_addr = 32'h8; d_we = 1'b0;
    if_req = 1'b1; d_req = 1'b1;
    for (int t = 0; t < c_ncont; t++)
      sb.push_back('{(t % 2 == 0), (t % 2 == 0) ? init_word(2) : init_word(1), 1'b1, 3});
    for (int c = 1; c <= 40 && n_done < c_ncont; c++) begin
      @(negedge clk);
      cnt++;
      vectors++;
      if (if_ack_a[sel] && d_ack_a[sel]) begin
        errors++; $display("FAIL cont_overlap got both acks want one");
      end
      if (if_ack_a[sel] || d_ack_a[sel]) begin
        got_d = d_ack_a[sel];
        n_done++;
        if (!c_rr || n_done == c_ncont) begin
          if (got_d) d_req = 1'b0; else if_req = 1'b0;
        end
        if (n_done == c_ncont) begin if_req = 1'b0; d_req = 1'b0; end
        e = sb.pop_front();
        if (got_d !== e.is_d || gnt_d_a[sel] !== e.is_d) begin
          errors++;
          $display("FAIL cont_owner%0d got d=%b gnt=%b want %b", n_done, got_d, gnt_d_a[sel], e.is_d);
        end
        if ((got_d ? d_rdata_a[sel] : if_rdata_a[sel]) !== e.data) begin
          errors++;
          $display("FAIL cont_data%0d got %h want %h", n_done,
                   got_d ? d_rdata_a[sel] : if_rdata_a[sel], e.data);
        end
        if (cnt !== e.lat) begin
          errors++; $display("FAIL cont_lat%0d got %0d want %0d", n_done, cnt, e.lat);
        end
        cnt = 0;
      end
    end
    vectors++;
    if (n_done != c_ncont) begin
      errors++; $display("FAIL cont_timeout got %0d acks want %0d", n_done, c_ncont);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   last_en = -1, last_ack = 0, n = 0;
    sel = 0; do_reset();
    if_addr = 32'h0; if_req = 1'b1;
    for (int t = 0; t < 3; t++) sb.push_back('{1'b0, init_word(t), 1'b1, 3});
    for (int c = 1; c <= 20 && n < 3; c++) begin
      @(negedge clk);
      if (mem_en_a[sel]) begin
        if (last_en >= 0) begin
          vectors++;
          if (c - last_en !== 3) begin
            errors++; $display("FAIL b2b_en_gap got %0d want 3", c - last_en);
          end
        end
        last_en = c;
      end
      if (if_ack_a[sel]) begin
        e = sb.pop_front();
        vectors++;
        if (if_rdata_a[sel] !== e.data || c - last_ack !== e.lat) begin
          errors++;
          $display("FAIL b2b_ack%0d data=%h lat=%0d want %h/%0d", n, if_rdata_a[sel], c - last_ack, e.data, e.lat);
        end
        last_ack = c; n++;
        if (n < 3) if_addr = if_addr + 32'd4; else if_req = 1'b0;
      end
    end
    vectors++;
    if (n != 3) begin
      errors++; $display("FAIL b2b_timeout got %0d acks want 3", n);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    bit   done = 1'b0;
    sel = 2; do_reset();
    if_addr = 32'h8; if_req = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (busy_a[sel] !== 1'b1) begin
      errors++; $display("FAIL rmid_busy got %b want 1", busy_a[sel]);
    end
    rst = 1'b1; if_req = 1'b0;
    #1;
    vectors++;
    if ({mem_en_a[sel], if_ack_a[sel], d_ack_a[sel], busy_a[sel]} !== 4'd0) begin
      errors++;
      $display("FAIL rmid_async got %b want 0000", {mem_en_a[sel], if_ack_a[sel], d_ack_a[sel], busy_a[sel]});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      vectors++;
      if ({mem_en_a[sel], if_ack_a[sel], d_ack_a[sel]} !== 3'd0) begin
        errors++;
        $display("FAIL rmid_quiet got %b want 000", {mem_en_a[sel], if_ack_a[sel], d_ack_a[sel]});
      end
    end
    if_req = 1'b1;
    sb.push_back('{1'b0, init_word(2), 1'b1, 5});
    for (int c = 1; c <= 12 && !done; c++) begin
      @(negedge clk);
      if (if_ack_a[sel]) begin
        if_req = 1'b0; done = 1'b1;
        e = sb.pop_front();
        vectors++;
        if (if_rdata_a[sel] !== e.data || c !== e.lat) begin
          errors++;
          $display("FAIL rmid_retry data=%h lat=%0d want %h/%0d", if_rdata_a[sel], c, e.data, e.lat);
        end
      end
    end
    vectors++;
    if (!done) begin
      errors++; $display("FAIL rmid_timeout got no ack want ack");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fetch();
    test_store_load();
    test_contention();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port synchronous memory (BRAM) between the instruction-fetch requester (I, read-only) and the load/store requester (D, read/write).
- Sits between the fetch/LSU logic and the unified memory.
- Serialises accesses with a req/ack handshake, sequences the memory's fixed read latency and returns registered read data to the winning requester.

Parameters:
- ADDR_WIDTH, 32, byte-address width on all address ports.
- MEM_LATENCY, 1, memory read latency in cycles (legal 1..4). mem_rdata is valid MEM_LATENCY cycles after the mem_en cycle.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch read request; held with if_addr stable until if_ack.
- if_addr  in  ADDR_WIDTH  fetch byte address.
- if_ack  out  1  one-cycle completion strobe for the fetch request.
- if_rdata  out  32  fetched word; valid while if_ack=1, held until the next fetch ack.
- d_req  in  1  data request; held with d_we, d_be, d_addr and d_wdata stable until d_ack.
- d_we  in  1  1 = write, 0 = read.
- d_be  in  4  write byte enables.
- d_addr  in  ADDR_WIDTH  data byte address.
- d_wdata  in  32  store data.
- d_ack  out  1  one-cycle completion strobe for the data request.
- d_rdata  out  32  load word; valid while d_ack=1 on a read, held until the next data read ack.
- mem_en  out  1  memory enable, asserted for exactly one cycle per access.
- mem_we  out  4  byte write enables: d_be on a data write, otherwise 4'b0000.
- mem_addr  out  ADDR_WIDTH  address of the granted requester.
- mem_wdata  out  32  d_wdata on a data write, otherwise 0.
- mem_rdata  in  32  memory read data.
- busy  out  1  high while in WAIT.
- gnt_d  out  1  last grant owner: 1 = D, 0 = I.

Behaviour:
- Reset values: all outputs 0; state = IDLE; counter = 0; gnt_d = 0.
- All outputs are registered.
- States: IDLE, WAIT, RESP.
- Arbitration:
  - Sampled at the rising edge ending any IDLE or RESP cycle.
  - If any request is high: latch the winner and its command, go to WAIT.
  - Otherwise go to IDLE.
- Enable cycle E (first WAIT cycle): mem_en=1, mem_addr, mem_we and mem_wdata are driven. In all other cycles mem_en=0 and mem_we=0.
- Read WAIT:
  - Spans cycles E..E+MEM_LATENCY; a 3-bit counter is loaded with MEM_LATENCY and decrements.
  - mem_rdata is captured at the end of cycle E+MEM_LATENCY.
  - Next state is RESP.
- Write WAIT: spans cycle E only; next state is RESP.
- RESP:
  - Exactly one cycle.
  - The granted requester's ack = 1; read data appears on its rdata.
- Latency from the request-sampling edge to ack:
  - Read: MEM_LATENCY+2 cycles.
  - Write: 2 cycles.
- Handshake rules:
  - A requester drops req during its ack cycle.
  - A req still high at the edge ending the ack cycle counts as a new request (back-to-back, no idle cycle).
- Requests arriving while in WAIT wait until the next arbitration edge. They are never lost, because req is held.
- Simultaneous if_req and d_req: D wins (fixed priority; see Optional Feature).
- if_ack and d_ack are never high in the same cycle.
- Write with d_be=0: a one-cycle mem_en with mem_we=0 is still issued, and d_ack is still returned.
- rst asserted mid-operation:
  - Immediately forces IDLE with all outputs 0.
  - The in-flight access is abandoned and no ack is issued.
  - Requesters re-present after reset.
- Addresses pass through unmodified; alignment is the requester's responsibility.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined: when both requests are high at an arbitration edge, grant the requester opposite to gnt_d. A lone request is granted immediately.
- Not defined: fixed priority, D over I. gnt_d is still maintained.

Test Plan:
- Fetch read, MEM_LATENCY=1: if_req=1, if_addr=0x100, memory word at 0x100 = 0x00500093 -> mem_en=1 for one cycle with mem_addr=0x100, mem_we=0; if_ack one cycle with if_rdata=0x00500093, 3 cycles after the request edge; d_ack stays 0.
- Store then load, MEM_LATENCY=2:
  - Stimulus: d_we=1, d_be=4'b0011, d_addr=0x200, d_wdata=0xDEADBEEF, then a read of 0x200.
  - Response: write shows mem_we=4'b0011; d_ack 2 cycles after its request edge. Read d_ack arrives 4 cycles after its request edge; d_rdata equals the model memory (low half 0xBEEF).
- Contention, both requests high in IDLE:
  - Feature off: D is served first; I is served in the back-to-back slot after d_ack; no overlapping acks.
  - Feature on, both requests held for 4 transactions: grants alternate D, I, D, I.
- Back-to-back: if_req held high for 3 fetches at 0x0, 0x4, 0x8 with MEM_LATENCY=1 -> acks every 3 cycles; mem_en pulses spaced 3 cycles apart; no extra idle cycle.
- Reset mid-read: assert rst during the WAIT of a MEM_LATENCY=3 read -> in the same cycle mem_en, acks and busy are 0; no ack ever appears; after rst deasserts, a re-presented request completes normally.
